// File: rtl/reg_scrub_pkg.sv
// Shared types and constants for the background ECC register scrubber.
package reg_scrub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WBACK,
    ST_NEXT
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_CORR   = 2'b01;
  localparam logic [1:0] ERR_UNCORR = 2'b10;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/reg_scrubber_sat_counter.sv
// Parameterized-width event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (inc_i) begin
      count_o <= sat_inc(count_o);
    end
  end

endmodule

// File: rtl/reg_scrubber.sv
// Background ECC scrubber in front of register_file; yields to host traffic.
// Define REG_SCRUB_WRITEBACK_EN to repair corrected words; otherwise detect-only.
module reg_scrubber
  import reg_scrub_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int REGISTERS   = 32,
  parameter int REGDIRSIZE  = 5,
  parameter int COUNTERSIZE = 32,
  parameter int INTERVAL_W  = 16,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [INTERVAL_W-1:0]  interval_i,
  input  logic                   host_busy_i,
  input  logic                   host_wr_i,
  input  logic [REGDIRSIZE-1:0]  host_addr_i,
  output logic                   rf_req_o,
  output logic                   rf_we_o,
  output logic [REGDIRSIZE-1:0]  rf_addr_o,
  output logic [WORD_SIZE-1:0]   rf_wdata_o,
  input  logic [WORD_SIZE-1:0]   rf_rdata_i,
  input  logic                   rf_rvalid_i,
  input  logic [1:0]             rf_err_i,
  output logic [COUNTERSIZE-1:0] corrected_cnt_o,
  output logic [COUNTERSIZE-1:0] uncorr_cnt_o,
  output logic [REGDIRSIZE-1:0]  last_err_addr_o,
  output logic                   busy_o,
  output logic                   err_pulse_o
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                state, state_nxt;
  logic [REGDIRSIZE-1:0] ptr;
  logic [INTERVAL_W-1:0] ival_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  start, timeout, rsp_corr, rsp_bad;
  logic                  cancel, wb_go, go_wback;

  assign start    = enable_i && !host_busy_i && (ival_cnt >= interval_i);
  assign timeout  = (state == ST_WAIT) && !rf_rvalid_i && (to_cnt == TO_W'(TIMEOUT - 1));
  assign rsp_corr = (state == ST_WAIT) && rf_rvalid_i && (rf_err_i == ERR_CORR);
  assign rsp_bad  = (state == ST_WAIT) && rf_rvalid_i &&
                    (rf_err_i != ERR_NONE) && (rf_err_i != ERR_CORR);
  assign go_wback = rsp_corr && !cancel;

`ifdef REG_SCRUB_WRITEBACK_EN
  logic                 hazard, dirty;
  logic [WORD_SIZE-1:0] wb_data;

  // A host write to the word being scrubbed makes our corrected copy stale.
  assign hazard = host_wr_i && (host_addr_i == ptr) &&
                  ((state == ST_WAIT) || (state == ST_WBACK));
  assign cancel = hazard || dirty;
  assign wb_go  = (state == ST_WBACK) && !host_busy_i && !cancel;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dirty <= 1'b0;
    end else if (state == ST_NEXT) begin
      dirty <= 1'b0;
    end else if (hazard) begin
      dirty <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsp_corr) begin
      wb_data <= rf_rdata_i;
    end
  end

  assign rf_we_o    = wb_go;
  assign rf_wdata_o = wb_go ? wb_data : '0;
`else
  logic unused_inputs;

  assign unused_inputs = ^{host_wr_i, host_addr_i, rf_rdata_i};
  assign cancel        = 1'b1;
  assign wb_go         = 1'b0;
  assign rf_we_o       = 1'b0;
  assign rf_wdata_o    = '0;
`endif

  always_comb begin
    state_nxt = state;
    rf_req_o  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ: begin
        rf_req_o  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rf_rvalid_i)  state_nxt = go_wback ? ST_WBACK : ST_NEXT;
        else if (timeout) state_nxt = ST_NEXT;
      end
      ST_WBACK: begin
        rf_req_o = wb_go;
        if (cancel || !host_busy_i) state_nxt = ST_NEXT;
      end
      ST_NEXT:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      ival_cnt        <= '0;
      to_cnt          <= '0;
      last_err_addr_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_NEXT) begin
        ptr <= (ptr == REGDIRSIZE'(REGISTERS - 1)) ? '0 : ptr + REGDIRSIZE'(1);
      end
      if ((state == ST_NEXT) || ((state == ST_IDLE) && !enable_i)) begin
        ival_cnt <= '0;
      end else if ((state == ST_IDLE) && !(&ival_cnt)) begin
        ival_cnt <= ival_cnt + INTERVAL_W'(1);
      end
      to_cnt <= (state == ST_WAIT) ? to_cnt + TO_W'(1) : '0;
      if (rsp_corr || rsp_bad || timeout) begin
        last_err_addr_o <= ptr;
      end
    end
  end

  assign rf_addr_o   = ptr;
  assign busy_o      = (state != ST_IDLE);
  assign err_pulse_o = rsp_bad || timeout;

  sat_counter #(.WIDTH(COUNTERSIZE)) u_corr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (rsp_corr),
    .count_o (corrected_cnt_o)
  );

  sat_counter #(.WIDTH(COUNTERSIZE)) u_uncorr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (rsp_bad || timeout),
    .count_o (uncorr_cnt_o)
  );

endmodule

// File: tb/tb_reg_scrubber.sv
// Directed self-checking bench for reg_scrubber; the register file is modelled inline.
module tb_reg_scrubber;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [15:0] interval_i;
  logic        host_busy_i;
  logic        host_wr_i;
  logic [4:0]  host_addr_i;
  logic        rf_req_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] rf_rdata_i;
  logic        rf_rvalid_i;
  logic [1:0]  rf_err_i;
  logic [31:0] corrected_cnt_o;
  logic [31:0] uncorr_cnt_o;
  logic [4:0]  last_err_addr_o;
  logic        busy_o;
  logic        err_pulse_o;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          pulse_cnt = 0;
  int          exp_wr = 0;
  int          cyc;
  logic [31:0] wr_data_last = '0;
  logic [4:0]  exp_ptr;

  always #5 clk = ~clk;

  reg_scrubber dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .interval_i      (interval_i),
    .host_busy_i     (host_busy_i),
    .host_wr_i       (host_wr_i),
    .host_addr_i     (host_addr_i),
    .rf_req_o        (rf_req_o),
    .rf_we_o         (rf_we_o),
    .rf_addr_o       (rf_addr_o),
    .rf_wdata_o      (rf_wdata_o),
    .rf_rdata_i      (rf_rdata_i),
    .rf_rvalid_i     (rf_rvalid_i),
    .rf_err_i        (rf_err_i),
    .corrected_cnt_o (corrected_cnt_o),
    .uncorr_cnt_o    (uncorr_cnt_o),
    .last_err_addr_o (last_err_addr_o),
    .busy_o          (busy_o),
    .err_pulse_o     (err_pulse_o)
  );

  // Record register-file writes and error pulses mid-cycle.
  always @(negedge clk) begin
    if (rst_i) begin
      if (rf_req_o && rf_we_o) begin
        wr_cnt++;
        wr_data_last = rf_wdata_o;
      end
      if (err_pulse_o) pulse_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic [4:0] addr, input string tag, output int n);
    n = 0;
    while (rf_req_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 64'(rf_req_o), 64'd1);
    check({tag, "_addr"}, 64'(rf_addr_o), 64'(addr));
    check({tag, "_we"}, 64'(rf_we_o), 64'd0);
  endtask

  task automatic respond(input logic [1:0] err, input logic [31:0] data, input int lat);
    tick();
    repeat (lat - 1) tick();
    rf_rvalid_i = 1'b1;
    rf_err_i    = err;
    rf_rdata_i  = data;
    tick();
    rf_rvalid_i = 1'b0;
    rf_err_i    = 2'b00;
    rf_rdata_i  = '0;
  endtask

  task automatic scrub_clean(input string tag);
    wait_req(exp_ptr, tag, cyc);
    respond(2'b00, 32'h0, 1);
    exp_ptr = exp_ptr + 5'd1;
  endtask

  initial begin
    rst_i = 1'b0; enable_i = 1'b0; interval_i = '0; host_busy_i = 1'b0;
    host_wr_i = 1'b0; host_addr_i = '0; rf_rdata_i = '0; rf_rvalid_i = 1'b0; rf_err_i = '0;
    tick(); tick();
    check("rst_req", 64'(rf_req_o), 0);
    check("rst_we", 64'(rf_we_o), 0);
    check("rst_addr", 64'(rf_addr_o), 0);
    check("rst_wdata", 64'(rf_wdata_o), 0);
    check("rst_corr", 64'(corrected_cnt_o), 0);
    check("rst_uncorr", 64'(uncorr_cnt_o), 0);
    check("rst_lasterr", 64'(last_err_addr_o), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_pulse", 64'(err_pulse_o), 0);

    // Host priority: nothing issues while host_busy_i is high.
    rst_i = 1'b1; enable_i = 1'b1; host_busy_i = 1'b1;
    tick(); tick(); tick();
    check("hostbusy_req", 64'(rf_req_o), 0);
    check("hostbusy_busy", 64'(busy_o), 0);
    host_busy_i = 1'b0;
    exp_ptr = 5'd0;
    wait_req(exp_ptr, "first", cyc);
    check("first_latency", 64'(cyc), 1);
    respond(2'b00, 32'h0, 1);
    exp_ptr = 5'd1;

    // Clean scan through 31 and wrap back to 0.
    for (int i = 1; i <= 32; i++) begin
      wait_req(exp_ptr, "scan", cyc);
      check("scan_period", 64'(cyc), 2);
      respond(2'b00, 32'h0, (i == 10) ? 3 : 1);
      exp_ptr = exp_ptr + 5'd1;
    end
    check("scan_corr", 64'(corrected_cnt_o), 0);
    check("scan_uncorr", 64'(uncorr_cnt_o), 0);
    check("scan_writes", 64'(wr_cnt), 0);
    check("scan_pulses", 64'(pulse_cnt), 0);

    // Corrected error at address 5.
    while (exp_ptr != 5'd5) scrub_clean("to5");
    wait_req(5'd5, "corr5", cyc);
    respond(2'b01, 32'hDEADBEEF, 1);
    check("corr5_cnt", 64'(corrected_cnt_o), 1);
    check("corr5_last", 64'(last_err_addr_o), 5);
    check("corr5_uncorr", 64'(uncorr_cnt_o), 0);
`ifdef REG_SCRUB_WRITEBACK_EN
    check("corr5_wreq", 64'(rf_req_o), 1);
    check("corr5_wwe", 64'(rf_we_o), 1);
    check("corr5_waddr", 64'(rf_addr_o), 5);
    check("corr5_wdata", 64'(rf_wdata_o), 64'hDEADBEEF);
    exp_wr = 1;
`else
    check("corr5_noreq", 64'(rf_req_o), 0);
    check("corr5_nowe", 64'(rf_we_o), 0);
`endif
    tick();
    check("corr5_writes", 64'(wr_cnt), 64'(exp_wr));
    exp_ptr = 5'd6;

    // Uncorrectable at 7, timeout at 8, code 11 at 9.
    scrub_clean("to7");
    wait_req(5'd7, "unc7", cyc);
    respond(2'b10, 32'h12345678, 1);
    check("unc7_cnt", 64'(uncorr_cnt_o), 1);
    check("unc7_last", 64'(last_err_addr_o), 7);
    check("unc7_noreq", 64'(rf_req_o), 0);
    check("unc7_pulse_low", 64'(err_pulse_o), 0);
    tick();
    check("unc7_pulses", 64'(pulse_cnt), 1);
    check("unc7_writes", 64'(wr_cnt), 64'(exp_wr));

    wait_req(5'd8, "to8", cyc);
    tick();
    repeat (13) tick();
    check("to8_pulse_early", 64'(err_pulse_o), 0);
    check("to8_busy", 64'(busy_o), 1);
    tick();
    check("to8_pulse", 64'(err_pulse_o), 1);
    check("to8_cnt_before", 64'(uncorr_cnt_o), 1);
    tick();
    check("to8_cnt", 64'(uncorr_cnt_o), 2);
    check("to8_last", 64'(last_err_addr_o), 8);
    check("to8_pulses", 64'(pulse_cnt), 2);
    check("to8_pulse_off", 64'(err_pulse_o), 0);

    wait_req(5'd9, "e11", cyc);
    respond(2'b11, 32'h0, 1);
    check("e11_cnt", 64'(uncorr_cnt_o), 3);
    check("e11_last", 64'(last_err_addr_o), 9);
    check("e11_corr", 64'(corrected_cnt_o), 1);
    exp_ptr = 5'd10;

    // Host write to the scan address while writeback is stalled.
    while (exp_ptr != 5'd3) scrub_clean("to3");
    wait_req(5'd3, "haz3", cyc);
    tick();
    rf_rvalid_i = 1'b1; rf_err_i = 2'b01; rf_rdata_i = 32'hCAFEF00D; host_busy_i = 1'b1;
    tick();
    rf_rvalid_i = 1'b0; rf_err_i = 2'b00;
    check("haz3_corr", 64'(corrected_cnt_o), 2);
    check("haz3_last", 64'(last_err_addr_o), 3);
    check("haz3_stall", 64'(rf_req_o), 0);
    tick();
    check("haz3_stall2", 64'(rf_req_o), 0);
    host_wr_i = 1'b1; host_addr_i = 5'd3;
    #1;
    check("haz3_cancel", 64'(rf_req_o), 0);
    tick();
    host_wr_i = 1'b0; host_busy_i = 1'b0;
    check("haz3_writes", 64'(wr_cnt), 64'(exp_wr));
    exp_ptr = 5'd4;

    // Hazard observed during WAIT itself.
    wait_req(5'd4, "haz4", cyc);
    tick();
    rf_rvalid_i = 1'b1; rf_err_i = 2'b01; rf_rdata_i = 32'h44444444;
    host_wr_i = 1'b1; host_addr_i = 5'd4;
    tick();
    rf_rvalid_i = 1'b0; rf_err_i = 2'b00; host_wr_i = 1'b0;
    check("haz4_noreq", 64'(rf_req_o), 0);
    check("haz4_busy", 64'(busy_o), 1);
    tick();
    check("haz4_writes", 64'(wr_cnt), 64'(exp_wr));
    check("haz4_corr", 64'(corrected_cnt_o), 3);

    // Same-cycle host write as the writeback issue: cancel wins.
    wait_req(5'd5, "haz5", cyc);
    tick();
    rf_rvalid_i = 1'b1; rf_err_i = 2'b01; rf_rdata_i = 32'h0BADCAFE; host_busy_i = 1'b1;
    tick();
    rf_rvalid_i = 1'b0; rf_err_i = 2'b00;
    host_busy_i = 1'b0; host_wr_i = 1'b1; host_addr_i = 5'd5;
    #1;
    check("haz5_cancel", 64'(rf_req_o), 0);
    tick();
    host_wr_i = 1'b0;
    check("haz5_writes", 64'(wr_cnt), 64'(exp_wr));
    check("haz5_corr", 64'(corrected_cnt_o), 4);

    // Host write elsewhere does not block the writeback.
    wait_req(5'd6, "ok6", cyc);
    tick();
    rf_rvalid_i = 1'b1; rf_err_i = 2'b01; rf_rdata_i = 32'h55AA33CC;
    host_wr_i = 1'b1; host_addr_i = 5'd20;
    tick();
    rf_rvalid_i = 1'b0; rf_err_i = 2'b00; host_wr_i = 1'b0;
`ifdef REG_SCRUB_WRITEBACK_EN
    check("ok6_wreq", 64'(rf_req_o), 1);
    check("ok6_wwe", 64'(rf_we_o), 1);
    check("ok6_waddr", 64'(rf_addr_o), 6);
    check("ok6_wdata", 64'(rf_wdata_o), 64'h55AA33CC);
    exp_wr = exp_wr + 1;
`else
    check("ok6_noreq", 64'(rf_req_o), 0);
`endif
    tick();
    check("ok6_writes", 64'(wr_cnt), 64'(exp_wr));
`ifdef REG_SCRUB_WRITEBACK_EN
    check("ok6_lastdata", 64'(wr_data_last), 64'h55AA33CC);
`else
    check("ok6_lastdata", 64'(wr_data_last), 0);
`endif
    check("ok6_corr", 64'(corrected_cnt_o), 5);
    exp_ptr = 5'd7;

    // Idle interval of 3 cycles between scrubs.
    interval_i = 16'd3;
    scrub_clean("iv7");
    wait_req(5'd8, "iv8", cyc);
    check("iv8_gap", 64'(cyc), 5);
    respond(2'b00, 32'h0, 1);
    interval_i = 16'd0;

    // Disable mid-operation: the access completes, then scrubbing stops.
    wait_req(5'd9, "dis9", cyc);
    enable_i = 1'b0;
    respond(2'b00, 32'h0, 1);
    check("dis9_busy_next", 64'(busy_o), 1);
    tick();
    check("dis9_idle", 64'(busy_o), 0);
    repeat (6) tick();
    check("dis9_noreq", 64'(rf_req_o), 0);
    check("dis9_stillidle", 64'(busy_o), 0);

    // Reset asserted while waiting for read data.
    enable_i = 1'b1;
    wait_req(5'd10, "rst10", cyc);
    tick();
    check("rst10_inwait", 64'(busy_o), 1);
    rst_i = 1'b0;
    tick();
    check("mrst_busy", 64'(busy_o), 0);
    check("mrst_req", 64'(rf_req_o), 0);
    check("mrst_addr", 64'(rf_addr_o), 0);
    check("mrst_corr", 64'(corrected_cnt_o), 0);
    check("mrst_uncorr", 64'(uncorr_cnt_o), 0);
    check("mrst_last", 64'(last_err_addr_o), 0);
    check("mrst_pulse", 64'(err_pulse_o), 0);
    rst_i = 1'b1;
    wait_req(5'd0, "after_rst", cyc);
    respond(2'b00, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
